// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit bundle between the byte producers, the arbiter and uart_tx.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic                 grant_active;
  logic [2:0]           grant_id;
  logic                 timeout_pulse;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant_active, grant_id, timeout_pulse
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant_active, grant_id, timeout_pulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers,
// with per-message grant locking and an idle-timeout forced release.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter bit          LOCK_EN      = 1'b1,
  parameter int unsigned IDLE_TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);

  localparam int unsigned      CNT_W   = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = (IDLE_TIMEOUT > 0) ? CNT_W'(IDLE_TIMEOUT - 1) : '0;

  typedef enum logic {ARB, SEND} state_e;

  state_e           state_q, state_d;
  logic [2:0]       grant_id_q, grant_id_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic             grant_active_q, grant_active_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic                 sel_valid;
  logic                 sel_last;
  logic [7:0]           sel_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2*NUM_REQ-1:0] rotated;
  logic [3:0]           scan_sum;
  logic                 found;
  logic [2:0]           winner;
  logic                 do_release;

  // Signals of the currently granted requester.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        sel_valid    = bus.req_valid[i];
        sel_last     = bus.req_last[i];
        sel_data     = bus.req_data[8*i +: 8];
        req_ready[i] = (state_q == SEND) && bus.req_valid[i] && bus.tx_ready;
      end
    end
  end

  // Rotating the request vector by rr_ptr turns the wrapped search into a plain
  // lowest-index-first scan; bit k of the rotation is requester (rr_ptr+k) mod N.
  always_comb begin
    rotated  = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
    found    = 1'b0;
    winner   = '0;
    scan_sum = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && rotated[k]) begin
        found    = 1'b1;
        scan_sum = {1'b0, rr_ptr_q} + 4'(k);
        if (scan_sum >= 4'(NUM_REQ)) scan_sum = scan_sum - 4'(NUM_REQ);
        winner   = scan_sum[2:0];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_id_d      = grant_id_q;
    rr_ptr_d        = rr_ptr_q;
    grant_active_d  = grant_active_q;
    timeout_pulse_d = 1'b0;
    idle_cnt_d      = idle_cnt_q;
    do_release      = 1'b0;

    case (state_q)
      ARB: begin
        if (found) begin
          grant_id_d     = winner;
          grant_active_d = 1'b1;
          idle_cnt_d     = '0;
          state_d        = SEND;
        end
      end
      SEND: begin
        if (sel_valid) begin
          idle_cnt_d = '0;
          if (bus.tx_ready && (!LOCK_EN || sel_last)) do_release = 1'b1;
        end else if (IDLE_TIMEOUT != 0) begin
          if (idle_cnt_q == CNT_MAX) begin
            do_release      = 1'b1;
            timeout_pulse_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ARB;
    endcase

    if (do_release) begin
      rr_ptr_d       = (grant_id_q == 3'(NUM_REQ - 1)) ? '0 : grant_id_q + 3'd1;
      grant_active_d = 1'b0;
      idle_cnt_d     = '0;
      state_d        = ARB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ARB;
      grant_id_q      <= '0;
      rr_ptr_q        <= '0;
      grant_active_q  <= 1'b0;
      timeout_pulse_q <= 1'b0;
      idle_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      grant_id_q      <= grant_id_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_active_q  <= grant_active_d;
      timeout_pulse_q <= timeout_pulse_d;
      idle_cnt_q      <= idle_cnt_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.tx_valid      = (state_q == SEND) && sel_valid;
  assign bus.tx_data       = (state_q == SEND) ? sel_data : 8'h00;
  assign bus.grant_active  = grant_active_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter against a per-requester
// message-level reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .LOCK_EN      (1'b1),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [N-1:0]   v_valid = '0;
  logic [N-1:0]   v_last  = '0;
  logic [8*N-1:0] v_data  = '0;
  logic           v_txr   = 1'b0;

  assign bus.req_valid = v_valid;
  assign bus.req_last  = v_last;
  assign bus.req_data  = v_data;
  assign bus.tx_ready  = v_txr;

  // Requester byte streams: {last, data}
  logic [8:0]  mbuf [N][256];
  int unsigned head [N];
  int unsigned tail [N];
  logic [N-1:0] pres = '0;
  int gap_pct = 0;

  // Reference model: owner of the transmitter (-1 = arbitrating)
  int m_owner = -1, m_gid = 0, m_ptr = 0, m_idle = 0;
  bit m_tp = 1'b0;
  logic [N-1:0] e_ready;

  int nchk = 0, nfail = 0, cyc = 0;
  int log_id[$], log_dat[$], log_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit last);
    mbuf[r][tail[r] % 256] = {last, d};
    tail[r]++;
  endtask

  task automatic flush_all();
    for (int r = 0; r < N; r++) begin
      head[r] = tail[r];
      pres[r] = 1'b0;
      v_valid[r] = 1'b0;
      v_last[r] = 1'b0;
    end
  endtask

  task automatic tick();
    logic e_txv;
    logic [7:0] e_txd;
    bit got;
    int r;
    #1;
    e_txv = 1'b0;
    e_txd = 8'h00;
    if (m_owner >= 0) begin
      e_txv = v_valid[m_owner];
      e_txd = v_data[8*m_owner +: 8];
    end
    e_ready = '0;
    if (e_txv && v_txr) e_ready[m_owner] = 1'b1;
    chk("tx_valid", 32'(bus.tx_valid), 32'(e_txv));
    chk("tx_data", 32'(bus.tx_data), 32'(e_txd));
    chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
    chk("grant_active", 32'(bus.grant_active), 32'(m_owner >= 0));
    chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
    chk("timeout_pulse", 32'(bus.timeout_pulse), 32'(m_tp));
    if (bus.tx_valid && v_txr) begin
      log_id.push_back(int'(bus.grant_id));
      log_dat.push_back(int'(bus.tx_data));
      log_cyc.push_back(cyc);
    end

    if (rst) begin
      m_owner = -1; m_ptr = 0; m_gid = 0; m_idle = 0; m_tp = 1'b0;
    end else begin
      m_tp = 1'b0;
      if (m_owner < 0) begin
        got = 1'b0;
        for (int k = 0; k < N; k++) begin
          r = (m_ptr + k) % N;
          if (!got && v_valid[r]) begin
            got = 1'b1; m_owner = r; m_gid = r; m_idle = 0;
          end
        end
      end else if (v_valid[m_owner]) begin
        m_idle = 0;
        if (v_txr && v_last[m_owner]) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_tp = 1'b1;
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
          m_idle = 0;
        end
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    for (int q = 0; q < N; q++) begin
      if (pres[q] && e_ready[q]) begin
        head[q]++;
        pres[q] = 1'b0;
        v_valid[q] = 1'b0;
      end
      if (!pres[q] && head[q] != tail[q] && ($urandom_range(99) >= 32'(gap_pct))) begin
        pres[q] = 1'b1;
        v_valid[q] = 1'b1;
        {v_last[q], v_data[8*q +: 8]} = mbuf[q][head[q] % 256];
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_grant(input int id, input string tag);
    int n = 0;
    while (!(bus.grant_active && bus.grant_id == 3'(id)) && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {28'd0, bus.grant_active, bus.grant_id}, {28'd0, 1'b1, 3'(id)});
  endtask

  task automatic clear_log();
    log_id.delete(); log_dat.delete(); log_cyc.delete();
  endtask

  initial begin
    int n, base;
    int rr_exp [6];
    for (int r = 0; r < N; r++) begin head[r] = 0; tail[r] = 0; end
    rr_exp = '{0, 1, 3, 0, 1, 3};

    // Reset
    rst = 1'b1;
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    tick();

    // Single requester
    clear_log();
    v_txr = 1'b1;
    push(2, 8'h41, 1'b1);
    tick();
    tick();
    chk("single_grant", {28'd0, bus.grant_active, bus.grant_id}, 32'h0000_000a);
    run(4);
    chk("single_count", 32'(log_id.size()), 32'd1);
    if (log_id.size() > 0) begin
      chk("single_id", 32'(log_id[0]), 32'd2);
      chk("single_data", 32'(log_dat[0]), 32'h41);
    end
    chk("single_rr_ptr", 32'(dut.rr_ptr_q), 32'd3);

    // Round-robin over requesters 0,1,3
    rst = 1'b1; tick(); rst = 1'b0;
    clear_log();
    for (int m = 0; m < 2; m++) begin
      push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1); push(3, 8'hA3, 1'b1);
    end
    run(18);
    chk("rr_count", 32'(log_id.size()), 32'd6);
    for (int i = 0; i < 6 && i < log_id.size(); i++) chk("rr_order", 32'(log_id[i]), 32'(rr_exp[i]));
    for (int i = 0; i < 5 && i + 1 < log_cyc.size(); i++)
      chk("rr_spacing", 32'(log_cyc[i+1] - log_cyc[i]), 32'd2);

    // Locked 3-byte message from requester 1 while requester 0 waits
    clear_log();
    push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
    wait_grant(1, "lock_grant1");
    push(0, 8'h55, 1'b1);
    run(12);
    chk("lock_count", 32'(log_id.size()), 32'd4);
    if (log_id.size() >= 4) begin
      chk("lock_b0", {log_id[0][7:0], log_dat[0][7:0]}, 32'h0110);
      chk("lock_b1", {log_id[1][7:0], log_dat[1][7:0]}, 32'h0111);
      chk("lock_b2", {log_id[2][7:0], log_dat[2][7:0]}, 32'h0112);
      chk("lock_next", {log_id[3][7:0], log_dat[3][7:0]}, 32'h0055);
    end

    // Backpressure
    clear_log();
    v_txr = 1'b0;
    push(3, 8'h77, 1'b1);
    wait_grant(3, "bp_grant");
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("bp_tx_valid", 32'(bus.tx_valid), 32'd1);
      chk("bp_tx_data", 32'(bus.tx_data), 32'h77);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    v_txr = 1'b1;
    run(3);
    chk("bp_accepts", 32'(log_id.size()), 32'd1);

    // Idle timeout
    clear_log();
    push(0, 8'h21, 1'b0);
    wait_grant(0, "to_grant0");
    push(2, 8'h22, 1'b1);
    n = 0;
    while (!(bus.grant_active && bus.grant_id == 3'd0 && !v_valid[0]) && n < 20) begin
      tick(); n++;
    end
    chk("to_drop_seen", 32'(v_valid[0]), 32'd0);
    n = 0;
    while (!bus.timeout_pulse && n < 40) begin
      tick(); n++;
    end
    chk("to_latency", 32'(n), 32'd8);
    run(4);
    chk("to_count", 32'(log_id.size()), 32'd2);
    if (log_id.size() >= 2) begin
      chk("to_first", {log_id[0][7:0], log_dat[0][7:0]}, 32'h0021);
      chk("to_next", {log_id[1][7:0], log_dat[1][7:0]}, 32'h0222);
    end

    // Reset during the second byte of a locked 4-byte message
    clear_log();
    push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b0); push(1, 8'h34, 1'b1);
    n = 0;
    while (log_id.size() < 1 && n < 20) begin tick(); n++; end
    chk("rst_first_byte", 32'(log_id.size()), 32'd1);
    rst = 1'b1;
    tick();
    flush_all();
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_grant", {28'd0, bus.grant_active, bus.grant_id}, 32'd0);
    chk("rst_timeout", 32'(bus.timeout_pulse), 32'd0);
    rst = 1'b0;
    base = log_id.size();
    push(3, 8'h3A, 1'b1); push(0, 8'h0A, 1'b1);
    run(8);
    chk("rst_count", 32'(log_id.size() - base), 32'd2);
    if (log_id.size() > base) chk("rst_restart_id", 32'(log_id[base]), 32'd0);

    // Randomized traffic
    rst = 1'b1; tick(); rst = 1'b0;
    gap_pct = 25;
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < N; r++)
        if (tail[r] - head[r] < 16 && $urandom_range(5) == 0)
          push(r, 8'($urandom), $urandom_range(2) == 0);
      v_txr = ($urandom_range(3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
